audio_dac_serializer: RTL and testbench
=======================================

Name: audio_dac_serializer

Overview:
- Transmit-side partner of the audio-in path. Accepts processed stereo samples over the write_audio_out / audio_out_allowed handshake and buffers them in a small FIFO.
- Serializes each sample onto AUD_DACDAT in left-justified format, timed by the codec-mastered AUD_BCLK and AUD_DACLRCK.
- Sits between the effects datapath (gain, meters) and the WM8731 DAC pins. Replaces the vendor output path so underrun and overflow become visible.

Parameters:
- FIFO_DEPTH, 8, number of stereo pairs buffered; power of two, minimum 2.
- AUDIO_WIDTH, 24, bits serialized per channel, taken from sample[31 -: AUDIO_WIDTH].
- SYNC_STAGES, 2, synchronizer flops on AUD_BCLK and AUD_DACLRCK.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear_audio_out_memory  in  1  synchronous FIFO flush.
- left_channel_audio_out  in  32  left sample, two's complement.
- right_channel_audio_out  in  32  right sample, two's complement.
- write_audio_out  in  1  push strobe; one pair per cycle.
- audio_out_allowed  out  1  high when at least one FIFO slot is free.
- fifo_used  out  clog2(FIFO_DEPTH)+1  pairs currently buffered.
- underrun  out  1  one-cycle pulse when a left frame starts with the FIFO empty.
- overflow  out  1  sticky; set by a write while full, cleared by reset or clear.
- AUD_BCLK  in  1  codec bit clock, asynchronous to CLOCK_50.
- AUD_DACLRCK  in  1  codec frame clock; high = left channel.
- AUD_DACDAT  out  1  serial DAC data.

Behaviour:
- Reset (asynchronous, reset_n low): FIFO empty, fifo_used=0, audio_out_allowed=1, underrun=0, overflow=0, AUD_DACDAT=0, shift register=0, held right sample=0, bit counter=0.
- Sampling: AUD_BCLK and AUD_DACLRCK pass through SYNC_STAGES flops. Edges are detected on the synchronized copies by comparing with a one-cycle-delayed copy.
- Handshake:
  - audio_out_allowed = (fifo_used != FIFO_DEPTH), decoded combinationally from the count.
  - Push occurs when write_audio_out & audio_out_allowed. The pair is readable from the next cycle.
  - write_audio_out while full: data dropped, overflow set.
- Frame sequencing is a three-state FSM: IDLE, LEFT, RIGHT.
  - Synchronized LRCK rising edge, FIFO non-empty: pop one pair. Shift register <= left[31 -: AUDIO_WIDTH]. Right sample held. Go to LEFT.
  - LRCK rising edge, FIFO empty: shift register <= 0, held right <= 0, pulse underrun, go to LEFT.
  - LRCK falling edge: shift register <= held right, go to RIGHT.
  - AUD_DACDAT takes the MSB in the same cycle the frame edge is detected. This gives left-justified timing: MSB valid before the first BCLK rising edge of the frame.
  - Each synchronized BCLK falling edge after that shifts the next bit out and increments the bit counter.
  - After AUDIO_WIDTH bits, AUD_DACDAT=0 until the next LRCK edge.
  - IDLE is entered only from reset. The first LRCK falling edge seen in IDLE transmits zeros; the FIFO is not popped.
- A BCLK falling edge coinciding with an LRCK edge: the frame load wins and the bit counter resets to 0.
- Simultaneous push and pop in one cycle: both take effect, fifo_used unchanged.
- Pop when full with write_audio_out high in the same cycle: the write is rejected (audio_out_allowed was 0) and overflow is set.
- clear_audio_out_memory:
  - Empties the FIFO and clears overflow in one cycle.
  - Takes priority over push and pop in the same cycle.
  - The frame in the shift register completes unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_used is an explicit counter of width clog2(FIFO_DEPTH)+1.
- Latency: a sample written to an empty FIFO appears on AUD_DACDAT at the next LRCK rising edge, plus SYNC_STAGES+1 CLOCK_50 cycles.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_W=32 and the stereo pair struct {left, right} (64 bits);
  - FSM state enum {IDLE, LEFT, RIGHT}.
- One sub-module, audio_sample_fifo: synchronous FIFO of pairs with push, pop, clear, full, empty and count.
- Synchronizers and edge detect stay inline.

Test Plan:
- Model: BCLK=3.072 MHz, LRCK=48 kHz, 32 BCLK per half-frame.
- Push left=0x7FFFFF00, right=0x80000100 into an empty FIFO -> next left frame shows bits 0111…1 (24 bits) then zeros; right frame shows 1000…0001; underrun stays 0.
- No writes across two LRCK rising edges -> AUD_DACDAT=0 for both frames; underrun pulses exactly twice, each one cycle wide.
- Push 9 pairs back-to-back with FIFO_DEPTH=8 -> audio_out_allowed falls after the 8th push, fifo_used=8, overflow=1 after the 9th; the 9th pair never appears on AUD_DACDAT.
- With FIFO full, assert write_audio_out in the cycle of a pop -> write rejected, fifo_used=7.
- With FIFO at 4 pairs mid left frame, assert clear_audio_out_memory -> fifo_used=0 and overflow=0 next cycle; the current left and right bits finish; the next frame underruns.
- Deassert reset_n mid-frame while AUD_DACDAT=1 -> AUD_DACDAT=0 without a clock edge; after release the block stays in IDLE until the next LRCK rising edge, then resumes.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the audio output path: stereo pair layout and frame FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package audio_pkg;

  localparam int SAMPLE_W = 32;

  // One stereo sample pair as buffered in the output FIFO (left in the upper half).
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } frame_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo pairs with flush, full/empty flags and an explicit occupancy count.
// Latency: a pushed pair is visible on rd_dat the cycle after the push (first-word fall-through).
// Backpressure: pushes while full and pops while empty are ignored; clear wins over push and pop.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  stereo_pair_t wr_dat,
  output stereo_pair_t rd_dat,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  stereo_pair_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_dat  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Buffers stereo pairs and shifts them out left-justified on AUD_DACDAT, timed by codec BCLK/LRCK.
// Latency: first bit appears SYNC_STAGES+1 CLOCK_50 cycles after the LRCK edge reaches the pin.
// Backpressure: audio_out_allowed drops when the FIFO is full; writes then are dropped and flag overflow.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int AUDIO_WIDTH = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          clear_audio_out_memory,
  input  logic [31:0]                   left_channel_audio_out,
  input  logic [31:0]                   right_channel_audio_out,
  input  logic                          write_audio_out,
  output logic                          audio_out_allowed,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_used,
  output logic                          underrun,
  output logic                          overflow,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT
);

  localparam int BIT_W = $clog2(AUDIO_WIDTH + 1);
  localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(AUDIO_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(AUDIO_WIDTH - 1);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_d;
  logic                   lrck_d;
  logic                   bclk_fall;
  logic                   lrck_rise;
  logic                   lrck_fall;

  stereo_pair_t           wr_pair;
  stereo_pair_t           rd_pair;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;

  frame_state_t           state;
  frame_state_t           state_nxt;
  logic                   load_left;
  logic                   load_zero;
  logic                   load_right;
  logic [AUDIO_WIDTH-1:0] frame_word;
  logic [AUDIO_WIDTH-1:0] shift_reg;
  logic [AUDIO_WIDTH-1:0] held_right;
  logic [BIT_W-1:0]       bit_cnt;

  // Bring the codec clocks into CLOCK_50 and keep a delayed copy for edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_d    <= 1'b0;
      lrck_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      lrck_d    <= lrck_sync[SYNC_STAGES-1];
    end
  end

  assign bclk_fall = bclk_d && !bclk_sync[SYNC_STAGES-1];
  assign lrck_rise = !lrck_d && lrck_sync[SYNC_STAGES-1];
  assign lrck_fall = lrck_d && !lrck_sync[SYNC_STAGES-1];

  assign wr_pair           = '{left: left_channel_audio_out, right: right_channel_audio_out};
  assign audio_out_allowed = !fifo_full;
  assign fifo_push         = write_audio_out && audio_out_allowed;

  audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .clear  (clear_audio_out_memory),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_dat (wr_pair),
    .rd_dat (rd_pair),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_used)
  );

  // Only the top AUDIO_WIDTH bits of each channel are serialized.
  if (AUDIO_WIDTH < SAMPLE_W) begin : g_lsb
    logic unused_lsbs;
    assign unused_lsbs = ^{rd_pair.left[SAMPLE_W-AUDIO_WIDTH-1:0],
                           rd_pair.right[SAMPLE_W-AUDIO_WIDTH-1:0]};
  end

  // Frame state register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Frame sequencing: an LRCK edge selects what the next half-frame transmits.
  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    load_left  = 1'b0;
    load_zero  = 1'b0;
    load_right = 1'b0;
    if (lrck_rise) begin
      state_nxt = LEFT;
      // A flush in the same cycle empties the FIFO first, so treat it as an underrun.
      if (!fifo_empty && !clear_audio_out_memory) begin
        fifo_pop  = 1'b1;
        load_left = 1'b1;
      end else begin
        load_zero = 1'b1;
      end
    end else if (lrck_fall) begin
      state_nxt  = RIGHT;
      load_right = 1'b1;
    end
  end

  // Word loaded into the shifter on a frame edge; a right frame straight out of IDLE is silent.
  always_comb begin
    frame_word = '0;
    if (load_left)                         frame_word = rd_pair.left[SAMPLE_W-1 -: AUDIO_WIDTH];
    else if (load_right && state != IDLE)  frame_word = held_right;
  end

  // Right channel is captured at the left edge so the pair stays together even if the FIFO is flushed.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)       held_right <= '0;
    else if (load_left) held_right <= rd_pair.right[SAMPLE_W-1 -: AUDIO_WIDTH];
    else if (load_zero) held_right <= '0;
  end

  // Serializer: frame load beats a coincident BCLK fall; bits shift on BCLK falls, then zeros.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (load_left || load_zero || load_right) begin
      shift_reg  <= frame_word;
      bit_cnt    <= '0;
      AUD_DACDAT <= frame_word[AUDIO_WIDTH-1];
    end else if (bclk_fall && state != IDLE && bit_cnt != BIT_END) begin
      shift_reg  <= {shift_reg[AUDIO_WIDTH-2:0], 1'b0};
      bit_cnt    <= bit_cnt + BIT_W'(1);
      AUD_DACDAT <= (bit_cnt < BIT_LAST) ? shift_reg[AUDIO_WIDTH-2] : 1'b0;
    end
  end

  // Underrun pulse and sticky overflow flag; flush clears overflow.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= load_zero;
      if (clear_audio_out_memory)                      overflow <= 1'b0;
      else if (write_audio_out && !audio_out_allowed)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: codec clocks are driven as integer multiples of CLOCK_50.
// Latency: one BCLK period is 16 CLOCK_50 cycles, one half-frame is 32 BCLK periods.
// Backpressure: exercises full FIFO, rejected writes, flush and underrun.
module tb_audio_dac_serializer;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        clear_audio_out_memory;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        write_audio_out;
  logic        audio_out_allowed;
  logic [3:0]  fifo_used;
  logic        underrun;
  logic        overflow;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;

  int          errors = 0;
  int          checks = 0;
  int          ur_pulses = 0;
  int          ur_cycles = 0;
  logic        ur_prev = 1'b0;
  logic [3:0]  used_at_clr;
  logic        ovf_at_clr;
  logic [31:0] b;

  audio_dac_serializer #(.FIFO_DEPTH(8), .AUDIO_WIDTH(24), .SYNC_STAGES(2)) dut (
    .CLOCK_50                (CLOCK_50),
    .reset_n                 (reset_n),
    .clear_audio_out_memory  (clear_audio_out_memory),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .write_audio_out         (write_audio_out),
    .audio_out_allowed       (audio_out_allowed),
    .fifo_used               (fifo_used),
    .underrun                (underrun),
    .overflow                (overflow),
    .AUD_BCLK                (AUD_BCLK),
    .AUD_DACLRCK             (AUD_DACLRCK),
    .AUD_DACDAT              (AUD_DACDAT)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CLOCK_50 cycle, sampled on the falling edge; tracks underrun pulses and width.
  task automatic tick();
    @(negedge CLOCK_50);
    if (underrun) ur_cycles++;
    if (underrun && !ur_prev) ur_pulses++;
    ur_prev = underrun;
  endtask

  task automatic clr_ur();
    ur_pulses = 0;
    ur_cycles = 0;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    left_channel_audio_out  = l;
    right_channel_audio_out = r;
    write_audio_out = 1'b1;
    tick();
    write_audio_out = 1'b0;
  endtask

  // One half-frame: LRCK changes with a BCLK fall, DACDAT is captured just before each BCLK rise.
  task automatic half_frame(input logic lr, input int wr_at, input int clr_at,
                            input int rst_at, input int rel_at, output logic [31:0] bits);
    int t;
    t = 0;
    bits = '0;
    AUD_DACLRCK = lr;
    for (int i = 0; i < 32; i++) begin
      AUD_BCLK = 1'b0;
      for (int h = 0; h < 16; h++) begin
        if (h == 8) begin
          bits[31-i] = AUD_DACDAT;
          AUD_BCLK = 1'b1;
        end
        write_audio_out        = (t == wr_at);
        clear_audio_out_memory = (t == clr_at);
        if (t == rst_at) begin
          chk("dacdat_before_reset", 64'(AUD_DACDAT), 64'd1);
          reset_n = 1'b0;
          #1;
          chk("dacdat_async_reset", 64'(AUD_DACDAT), 64'd0);
        end
        if (t == rel_at) reset_n = 1'b1;
        tick();
        if (t == clr_at) begin
          used_at_clr = fifo_used;
          ovf_at_clr  = overflow;
        end
        t++;
      end
    end
    write_audio_out        = 1'b0;
    clear_audio_out_memory = 1'b0;
  endtask

  initial begin
    reset_n                 = 1'b0;
    clear_audio_out_memory  = 1'b0;
    left_channel_audio_out  = '0;
    right_channel_audio_out = '0;
    write_audio_out         = 1'b0;
    AUD_BCLK                = 1'b0;
    AUD_DACLRCK             = 1'b0;
    repeat (3) tick();
    chk("rst_dacdat",   64'(AUD_DACDAT),        64'd0);
    chk("rst_used",     64'(fifo_used),         64'd0);
    chk("rst_allowed",  64'(audio_out_allowed), 64'd1);
    chk("rst_underrun", 64'(underrun),          64'd0);
    chk("rst_overflow", 64'(overflow),          64'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Single pair into an empty FIFO.
    push(32'h7FFFFF00, 32'h80000100);
    chk("t1_used_after_push", 64'(fifo_used), 64'd1);
    clr_ur();
    half_frame(1'b1, -1, -1, -1, -1, b);
    chk("t1_left_bits", 64'(b), 64'h7FFFFF00);
    chk("t1_used_after_pop", 64'(fifo_used), 64'd0);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t1_right_bits", 64'(b), 64'h80000100);
    chk("t1_no_underrun", 64'(ur_pulses), 64'd0);

    // Two frames with nothing buffered.
    clr_ur();
    half_frame(1'b1, -1, -1, -1, -1, b);
    chk("t2_left0_bits", 64'(b), 64'd0);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t2_right0_bits", 64'(b), 64'd0);
    half_frame(1'b1, -1, -1, -1, -1, b);
    chk("t2_left1_bits", 64'(b), 64'd0);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t2_right1_bits", 64'(b), 64'd0);
    chk("t2_underrun_pulses", 64'(ur_pulses), 64'd2);
    chk("t2_underrun_cycles", 64'(ur_cycles), 64'd2);

    // Nine back-to-back writes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      left_channel_audio_out  = {4'hA, 4'(i), 16'h1234, 8'hFF};
      right_channel_audio_out = {4'h5, 4'(i), 16'hC3C3, 8'hEE};
      write_audio_out = 1'b1;
      tick();
      if (i == 6) chk("t3_allowed_after_7", 64'(audio_out_allowed), 64'd1);
      if (i == 7) begin
        chk("t3_allowed_after_8",  64'(audio_out_allowed), 64'd0);
        chk("t3_used_after_8",     64'(fifo_used),         64'd8);
        chk("t3_overflow_after_8", 64'(overflow),          64'd0);
      end
      if (i == 8) begin
        chk("t3_overflow_after_9", 64'(overflow),  64'd1);
        chk("t3_used_after_9",     64'(fifo_used), 64'd8);
      end
    end
    write_audio_out = 1'b0;

    // Write asserted exactly in the pop cycle of a full FIFO: it must be rejected.
    left_channel_audio_out  = 32'hDEADBEEF;
    right_channel_audio_out = 32'hCAFEF00D;
    clr_ur();
    half_frame(1'b1, 2, -1, -1, -1, b);
    chk("t4_left_pair0", 64'(b), 64'({4'hA, 4'h0, 16'h1234, 8'h00}));
    chk("t4_used_after_pop", 64'(fifo_used), 64'd7);
    chk("t4_overflow_sticky", 64'(overflow), 64'd1);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t4_right_pair0", 64'(b), 64'({4'h5, 4'h0, 16'hC3C3, 8'h00}));
    for (int i = 1; i < 8; i++) begin
      half_frame(1'b1, -1, -1, -1, -1, b);
      chk("t4_left_pair", 64'(b), 64'({4'hA, 4'(i), 16'h1234, 8'h00}));
      half_frame(1'b0, -1, -1, -1, -1, b);
      chk("t4_right_pair", 64'(b), 64'({4'h5, 4'(i), 16'hC3C3, 8'h00}));
    end
    chk("t4_no_underrun_while_buffered", 64'(ur_pulses), 64'd0);
    half_frame(1'b1, -1, -1, -1, -1, b);
    chk("t4_ninth_never_sent_left", 64'(b), 64'd0);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t4_ninth_never_sent_right", 64'(b), 64'd0);
    chk("t4_underrun_after_drain", 64'(ur_pulses), 64'd1);
    chk("t4_used_drained", 64'(fifo_used), 64'd0);
    chk("t4_overflow_still_set", 64'(overflow), 64'd1);

    // Flush mid left frame with four pairs buffered.
    for (int i = 0; i < 4; i++) push({8'h10 + 8'(i), 16'hF0F0, 8'h55}, {8'h20 + 8'(i), 16'h0F0F, 8'hAA});
    chk("t5_used_before_clear", 64'(fifo_used), 64'd4);
    clr_ur();
    half_frame(1'b1, -1, 200, -1, -1, b);
    chk("t5_used_after_clear", 64'(used_at_clr), 64'd0);
    chk("t5_overflow_after_clear", 64'(ovf_at_clr), 64'd0);
    chk("t5_left_completes", 64'(b), 64'h10F0F000);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t5_right_completes", 64'(b), 64'h200F0F00);
    chk("t5_no_underrun_yet", 64'(ur_pulses), 64'd0);
    half_frame(1'b1, -1, -1, -1, -1, b);
    chk("t5_next_left_silent", 64'(b), 64'd0);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t5_next_right_silent", 64'(b), 64'd0);
    chk("t5_next_frame_underruns", 64'(ur_pulses), 64'd1);

    // Asynchronous reset in the middle of an all-ones left frame, released during the right half.
    push(32'hFFFFFF00, 32'h12345678);
    clr_ur();
    half_frame(1'b1, -1, -1, 200, -1, b);
    chk("t6_used_in_reset",     64'(fifo_used),         64'd0);
    chk("t6_allowed_in_reset",  64'(audio_out_allowed), 64'd1);
    chk("t6_overflow_in_reset", 64'(overflow),          64'd0);
    half_frame(1'b0, -1, -1, -1, 100, b);
    chk("t6_idle_right_silent", 64'(b), 64'd0);
    push(32'h13579BDF, 32'h2468ACE0);
    half_frame(1'b1, -1, -1, -1, -1, b);
    chk("t6_resume_left", 64'(b), 64'h13579B00);
    half_frame(1'b0, -1, -1, -1, -1, b);
    chk("t6_resume_right", 64'(b), 64'h2468AC00);
    chk("t6_no_underrun", 64'(ur_pulses), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
